// File: rtl/uart_tx_feeder.sv
//-----------------------------------------------------------------------------
// uart_tx_feeder
//
// Byte buffer and handshake sequencer placed directly in front of the UART
// transmitter. System-side bytes are queued in a small synchronous FIFO and
// handed to the transmitter one at a time. A Data_Valid pulse is only issued
// while the transmitter is idle. The presented byte is held stable until the
// transmitter has finished with it.
//
// Parameters:
//   DEPTH        FIFO entries (power of two, >= 2)
//   DATA_WIDTH   byte width, must match the transmitter's P_DATA width
//   ACK_TIMEOUT  cycles to wait for TX_BUSY after a pulse before re-pulsing
//
// Ports:
//   CLK        in   single clock, rising edge
//   RST        in   synchronous active-high reset
//   WR_DATA    in   byte to enqueue
//   WR_EN      in   enqueue request, accepted when FULL=0
//   FULL       out  occupancy == DEPTH
//   EMPTY      out  occupancy == 0
//   COUNT      out  current occupancy
//   OVF        out  one-cycle pulse when a write is attempted while FULL
//   TX_P_DATA  out  byte presented to the transmitter
//   TX_D_VLD   out  one-cycle Data_Valid pulse to the transmitter
//   TX_BUSY    in   transmitter busy flag
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_feeder #(
  parameter int DEPTH       = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 3
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   WR_DATA,
  input  logic                    WR_EN,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic [$clog2(DEPTH):0]  COUNT,
  output logic                    OVF,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    TX_BUSY
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic [ACK_W-1:0]       ack_cnt;
  logic [ACK_W-1:0]       ack_cnt_next;
  logic                   do_write;
  logic                   do_pop;

  assign FULL     = (count == CW'(DEPTH));
  assign EMPTY    = (count == '0);
  assign COUNT    = count;
  // Decoded straight from the state register so the pulse is glitch-free.
  assign TX_D_VLD = (state == SEND);

  // FULL blocks a write even when a pop happens in the same cycle.
  assign do_write = WR_EN && !FULL;

  // Next-state logic. The pop is issued only on the IDLE->SEND transition,
  // so a timeout retry re-pulses the byte already held in TX_P_DATA.
  always_comb begin
    state_next   = state;
    ack_cnt_next = ack_cnt;
    do_pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!EMPTY && !TX_BUSY) begin
          do_pop     = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        ack_cnt_next = '0;
        state_next   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (TX_BUSY) begin
          state_next = WAIT_DONE;
        end else begin
          // Reaching ACK_TIMEOUT after ACK_TIMEOUT silent cycles sends us back
          // to SEND, giving a re-pulse period of ACK_TIMEOUT+1 cycles.
          ack_cnt_next = ack_cnt + ACK_W'(1);
          if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
            state_next = SEND;
          end
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Sequencer state, FIFO pointers/occupancy, presented byte and overflow flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      ack_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      OVF       <= 1'b0;
      TX_P_DATA <= '0;
    end else begin
      state   <= state_next;
      ack_cnt <= ack_cnt_next;
      OVF     <= WR_EN && FULL;
      // DEPTH is a power of two, so pointer increments wrap naturally.
      if (do_write) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        TX_P_DATA <= mem[rd_ptr];
      end
      case ({do_write, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array is not reset; clearing the pointers discards its contents.
  always_ff @(posedge CLK) begin
    if (do_write) begin
      mem[wr_ptr] <= WR_DATA;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
//-----------------------------------------------------------------------------
// tb_uart_tx_feeder
//
// Directed testbench for uart_tx_feeder. A small behavioural transmitter
// raises busy one cycle after each Data_Valid pulse and holds it for HOLD
// cycles. Presented bytes are compared against an expected-order queue, and
// the busy-fall to Data_Valid spacing is measured where relevant.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_tx_feeder;

  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int HOLD  = 110;

  logic           CLK = 1'b0;
  logic           RST;
  logic [DW-1:0]  WR_DATA;
  logic           WR_EN;
  logic           FULL;
  logic           EMPTY;
  logic [3:0]     COUNT;
  logic           OVF;
  logic [DW-1:0]  TX_P_DATA;
  logic           TX_D_VLD;
  logic           TX_BUSY;

  uart_tx_feeder #(
    .DEPTH       (DEPTH),
    .DATA_WIDTH  (DW),
    .ACK_TIMEOUT (3)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .WR_DATA   (WR_DATA),
    .WR_EN     (WR_EN),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .COUNT     (COUNT),
    .OVF       (OVF),
    .TX_P_DATA (TX_P_DATA),
    .TX_D_VLD  (TX_D_VLD),
    .TX_BUSY   (TX_BUSY)
  );

  always #5 CLK = ~CLK;

  int         checks      = 0;
  int         errors      = 0;
  int         cycle       = 0;
  bit         model_en    = 1'b1;
  bit         stuck_busy  = 1'b0;
  bit         start_next  = 1'b0;
  bit         check_order = 1'b1;
  bit         check_gap   = 1'b0;
  int         busy_left   = 0;
  int         fall_cycle  = -1;
  int         vld_count   = 0;
  int         ovf_count   = 0;
  logic       prev_busy   = 1'b0;
  logic [7:0] last_data   = 8'h00;
  logic [7:0] exp_q [$];

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, actual, expected, cycle);
    end
  endtask

  // Advance one clock, update the transmitter model and observe outputs.
  task automatic tick();
    @(posedge CLK);
    #1;
    cycle++;
    if (model_en) begin
      if (start_next) begin
        busy_left  = HOLD;
        start_next = 1'b0;
      end
      TX_BUSY = (busy_left > 0) || stuck_busy;
      if (busy_left > 0) busy_left--;
      if (TX_BUSY && busy_left == 0 && !stuck_busy)
        checkOutput("data_held_busy", TX_P_DATA, last_data);
    end
    if (prev_busy && !TX_BUSY) fall_cycle = cycle;
    prev_busy = TX_BUSY;
    if (TX_D_VLD) begin
      vld_count++;
      if (check_order) begin
        if (exp_q.size() > 0) checkOutput("order", TX_P_DATA, exp_q.pop_front());
        else checkOutput("vld_while_nothing_expected", TX_D_VLD, 0);
      end
      if (check_gap && fall_cycle >= 0)
        checkOutput("gap_after_busy", cycle - fall_cycle, 2);
      fall_cycle = -1;
      last_data  = TX_P_DATA;
      if (model_en) start_next = 1'b1;
    end
    if (OVF) ovf_count++;
  endtask

  // Present one write for a single edge.
  task automatic applyStimulus(input logic [7:0] data);
    WR_DATA = data;
    WR_EN   = 1'b1;
    tick();
    WR_EN   = 1'b0;
  endtask

  // Run until the FIFO is empty and the transmitter model is quiet.
  task automatic waitIdle(input int budget);
    int n = 0;
    while (!(EMPTY && !TX_BUSY && busy_left == 0 && !start_next) && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain_within_budget", (n < budget), 1);
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST = 1'b1; WR_EN = 1'b0; WR_DATA = '0; TX_BUSY = 1'b0;

    // Reset, then idle for 20 cycles.
    tick(); tick();
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("rst_count", COUNT, 0);
      checkOutput("rst_empty", EMPTY, 1);
      checkOutput("rst_full", FULL, 0);
      checkOutput("rst_vld", TX_D_VLD, 0);
      checkOutput("rst_data", TX_P_DATA, 8'h00);
      checkOutput("rst_ovf", OVF, 0);
    end

    // Single byte: Data_Valid two edges after the write edge.
    $display("[TB] single byte");
    vld_count = 0; fall_cycle = -1; check_gap = 1'b0;
    exp_q = '{8'hA5};
    applyStimulus(8'hA5);
    checkOutput("single_count1", COUNT, 1);
    checkOutput("single_novld_yet", TX_D_VLD, 0);
    checkOutput("single_notempty", EMPTY, 0);
    tick();
    checkOutput("single_vld", TX_D_VLD, 1);
    checkOutput("single_data", TX_P_DATA, 8'hA5);
    checkOutput("single_count0", COUNT, 0);
    tick();
    checkOutput("single_vld_pulse", TX_D_VLD, 0);
    waitIdle(300);
    checkOutput("single_empty_after", EMPTY, 1);
    checkOutput("single_data_kept", TX_P_DATA, 8'hA5);
    checkOutput("single_vld_count", vld_count, 1);
    checkOutput("single_queue_done", exp_q.size(), 0);

    // Burst of 8 with ordering and 2-cycle spacing after busy falls.
    $display("[TB] burst and ordering");
    vld_count = 0; fall_cycle = -1; check_gap = 1'b1;
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
    checkOutput("burst_count_after_writes", COUNT, 7);
    checkOutput("burst_full_after_writes", FULL, 0);
    waitIdle(2000);
    checkOutput("burst_vld_count", vld_count, 8);
    checkOutput("burst_queue_done", exp_q.size(), 0);
    checkOutput("burst_empty", EMPTY, 1);

    // Overflow with the transmitter stalled.
    $display("[TB] overflow");
    vld_count = 0; ovf_count = 0; check_gap = 1'b0;
    stuck_busy = 1'b1;
    tick();
    exp_q = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87};
    for (int i = 0; i < 8; i++) applyStimulus(8'h80 + 8'(i));
    checkOutput("ovf_full", FULL, 1);
    checkOutput("ovf_count8", COUNT, 8);
    checkOutput("ovf_no_pulse_yet", OVF, 0);
    applyStimulus(8'hFF);
    checkOutput("ovf_pulse", OVF, 1);
    checkOutput("ovf_count_stays", COUNT, 8);
    tick();
    checkOutput("ovf_pulse_one_cycle", OVF, 0);
    checkOutput("ovf_pulse_total", ovf_count, 1);
    checkOutput("ovf_no_vld_while_busy", vld_count, 0);
    stuck_busy = 1'b0;
    waitIdle(2000);
    checkOutput("ovf_vld_count", vld_count, 8);
    checkOutput("ovf_queue_done", exp_q.size(), 0);

    // Ack timeout: busy held low, same byte re-pulsed every 4 cycles.
    $display("[TB] ack timeout");
    model_en = 1'b0; check_order = 1'b0; TX_BUSY = 1'b0; vld_count = 0;
    applyStimulus(8'h3C);
    tick();
    checkOutput("to_first_vld", TX_D_VLD, 1);
    checkOutput("to_first_data", TX_P_DATA, 8'h3C);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        checkOutput("to_gap_novld", TX_D_VLD, 0);
      end
      tick();
      checkOutput("to_repulse_vld", TX_D_VLD, 1);
      checkOutput("to_repulse_data", TX_P_DATA, 8'h3C);
      checkOutput("to_count0", COUNT, 0);
    end
    TX_BUSY = 1'b1;
    applyStimulus(8'h5A);
    for (int k = 0; k < 9; k++) tick();
    checkOutput("to_no_vld_in_wait_done", vld_count, 3);
    checkOutput("to_no_extra_pop", COUNT, 1);
    checkOutput("to_data_held", TX_P_DATA, 8'h3C);
    TX_BUSY = 1'b0;
    tick();
    checkOutput("to_idle_novld", TX_D_VLD, 0);
    tick();
    checkOutput("to_next_vld", TX_D_VLD, 1);
    checkOutput("to_next_data", TX_P_DATA, 8'h5A);
    checkOutput("to_next_count", COUNT, 0);
    TX_BUSY = 1'b1;
    tick(); tick();
    TX_BUSY = 1'b0;
    tick(); tick();
    checkOutput("to_final_empty", EMPTY, 1);
    model_en = 1'b1; check_order = 1'b1; busy_left = 0; start_next = 1'b0;

    // Reset while the first of three queued bytes is in flight.
    $display("[TB] reset mid-operation");
    vld_count = 0; check_gap = 1'b0;
    exp_q = '{8'h11};
    stuck_busy = 1'b1;
    tick();
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    checkOutput("mid_count3", COUNT, 3);
    stuck_busy = 1'b0;
    begin
      int n = 0;
      while (vld_count == 0 && n < 50) begin
        tick();
        n++;
      end
    end
    checkOutput("mid_first_vld", vld_count, 1);
    repeat (5) tick();
    checkOutput("mid_busy_before_rst", TX_BUSY, 1);
    checkOutput("mid_count2", COUNT, 2);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    last_data = 8'h00;
    checkOutput("mid_rst_count", COUNT, 0);
    checkOutput("mid_rst_vld", TX_D_VLD, 0);
    checkOutput("mid_rst_empty", EMPTY, 1);
    checkOutput("mid_rst_data", TX_P_DATA, 8'h00);
    repeat (200) tick();
    checkOutput("mid_no_replay", vld_count, 1);
    checkOutput("mid_count_after", COUNT, 0);
    checkOutput("mid_queue_done", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte buffer and handshake sequencer that sits directly upstream of the UART transmitter. Accepts bytes from the system side into a synchronous FIFO. Presents them one at a time on the transmitter's parallel-data / data-valid inputs, issuing each Data_Valid pulse only when the transmitter is idle. Holds the presented byte stable until the transmitter drops busy, because the transmitter's parity and serializer stages sample the data on the Data_Valid cycle.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥ 2
- DATA_WIDTH, 8, byte width; must match the transmitter's P_DATA width
- ACK_TIMEOUT, 3, cycles to wait for TX_BUSY to rise after a Data_Valid pulse before re-pulsing; ≥ 1

Ports:
- CLK  in  1  single clock; all logic on the rising edge
- RST  in  1  reset, synchronous, active-high
- WR_DATA  in  DATA_WIDTH  byte to enqueue
- WR_EN  in  1  enqueue request; accepted when FULL=0
- FULL  out  1  COUNT == DEPTH
- EMPTY  out  1  COUNT == 0
- COUNT  out  $clog2(DEPTH)+1  current occupancy
- OVF  out  1  one-cycle pulse when WR_EN=1 while FULL=1; the byte is dropped
- TX_P_DATA  out  DATA_WIDTH  byte presented to the transmitter
- TX_D_VLD  out  1  one-cycle Data_Valid pulse to the transmitter
- TX_BUSY  in  1  transmitter busy flag

## Operation
- FIFO: circular buffer with rd/wr pointers and an occupancy counter.
  - Write when WR_EN & !FULL. Pop only on the IDLE→SEND transition.
  - Write and pop in the same cycle: COUNT unchanged, both pointers advance, and the pointers wrap modulo DEPTH.
  - FULL blocks a write even if a pop occurs the same cycle.
  - No bypass path: a byte written while EMPTY=1 cannot be presented in that cycle.
- Sequencer states: IDLE, SEND, WAIT_ACK, WAIT_DONE.
  - IDLE: if COUNT>0 and TX_BUSY=0, pop the head into the TX_P_DATA register and go to SEND. Otherwise stay in IDLE.
  - SEND: TX_D_VLD=1 for this cycle only. Clear the ack counter and go to WAIT_ACK.
  - WAIT_ACK: if TX_BUSY=1, go to WAIT_DONE. Otherwise increment the ack counter. When the counter reaches ACK_TIMEOUT, go back to SEND and re-pulse the same byte; no second pop occurs.
  - WAIT_DONE: stay while TX_BUSY=1. Go to IDLE when TX_BUSY=0.
- TX_D_VLD is decoded from the state register (state == SEND), so it is glitch-free and registered.
- TX_P_DATA changes only on the IDLE→SEND edge. It stays constant through SEND, WAIT_ACK and WAIT_DONE, and keeps its last value while IDLE.
- OVF is a registered pulse and does not stall the sequencer.

## Timing
- Reset (RST=1 sampled at an edge):
  - state = IDLE; pointers = 0; COUNT = 0; EMPTY = 1; FULL = 0
  - OVF = 0; TX_D_VLD = 0; TX_P_DATA = 0
  - All FIFO contents are discarded.
- Reset mid-frame: TX_D_VLD is 0 from the cycle after reset. No byte is replayed. The transmitter finishes its current frame independently.
- Latency: a write accepted at edge n raises COUNT after edge n. With the sequencer in IDLE and TX_BUSY=0, TX_D_VLD is high during cycle n+2, with TX_P_DATA already valid in that cycle.
- Per byte: a minimum of 1 IDLE cycle, 1 SEND cycle and ≥ 1 WAIT_ACK cycle, followed by the full busy period of the frame.
- The gap between the last busy cycle and the next TX_D_VLD is 2 cycles: IDLE, then SEND.
- TX_BUSY already high in IDLE (transmitter still busy from another source): no pop, and the sequencer waits.
- Timeout retry: with TX_BUSY stuck at 0, TX_D_VLD pulses every ACK_TIMEOUT+1 cycles with the same data.
- COUNT, FULL and EMPTY update at the edge after the write or pop.

## Test plan
- Reset then idle: RST for 2 cycles → COUNT=0, EMPTY=1, FULL=0, TX_D_VLD=0, TX_P_DATA=0x00 and OVF=0 for 20 cycles.
- Single byte: write 0xA5 at edge n; the transmitter model raises busy 1 cycle after TX_D_VLD, holding it for 110 cycles → one TX_D_VLD pulse in cycle n+2 with TX_P_DATA=0xA5 held until busy falls; EMPTY=1 afterwards.
- Burst and ordering: write 0x01..0x08 back-to-back (DEPTH=8) → FULL=1 after the 8th write (earlier pops may lower it); bytes are presented in order 0x01..0x08; each TX_D_VLD occurs exactly 2 cycles after busy falls.
- Overflow: fill 8 entries with the transmitter stalled busy, then write 0xFF → OVF high for 1 cycle, COUNT stays 8, 0xFF is never presented.
- Ack timeout: TX_BUSY tied 0, write 0x3C → TX_D_VLD pulses every 4 cycles with 0x3C and COUNT=0; release busy to 1 → the sequencer enters WAIT_DONE, with no extra pop.
- Reset mid-operation: 3 bytes queued, assert RST while in WAIT_DONE → the next cycle shows COUNT=0 and TX_D_VLD=0, and no queued byte is ever presented.
